// File: rtl/maxpool_engine_if.sv
// Layer-memory port bundle shared by the CONV pipeline stages.
// The master side issues reads and writes; the slave side is the layer memory.
interface maxpool_engine_if #(
   parameter int DW = 20,
   parameter int AW = 12
);
   logic          crd;
   logic [AW-1:0] caddr_rd;
   logic [DW-1:0] cdata_rd;
   logic          cwr;
   logic [AW-1:0] caddr_wr;
   logic [DW-1:0] cdata_wr;
   logic [2:0]    csel;

   modport master (
      output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
      input  cdata_rd
   );

   modport slave (
      input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
      output cdata_rd
   );
endinterface

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 signed max-pooling of the layer-0 image into layer 1.
// Five cycles per output pixel: four reads, then one write of the block maximum.
module maxpool_engine #(
   parameter int IMG_W = 64,
   parameter int DW    = 20,
   parameter int AW    = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   maxpool_engine_if.master mem
);

   localparam int CW = $clog2(IMG_W / 2);

   localparam logic [2:0] CSEL_IDLE = 3'b000;
   localparam logic [2:0] CSEL_L0   = 3'b001;
   localparam logic [2:0] CSEL_L1   = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WR, S_FIN
   } state_e;

   state_e        state_q, state_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          crd_q, crd_d;
   logic          cwr_q, cwr_d;
   logic [2:0]    csel_q, csel_d;
   logic [AW-1:0] caddr_rd_q, caddr_rd_d;
   logic [AW-1:0] caddr_wr_q, caddr_wr_d;
   logic [CW-1:0] oy_q, oy_d;
   logic [CW-1:0] ox_q, ox_d;
   logic [DW-1:0] max_q, max_d;
   logic          row_odd, col_odd;
   logic          last_pixel;

   function automatic logic signed_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return $signed(a) > $signed(b);
   endfunction

   assign last_pixel = (oy_q == {CW{1'b1}}) && (ox_q == {CW{1'b1}});

   // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      oy_d    = oy_q;
      ox_d    = ox_q;
      max_d   = max_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD0;
               oy_d    = '0;
               ox_d    = '0;
            end
         end
         S_RD0: state_d = S_RD1;
         S_RD1: begin
            state_d = S_RD2;
            max_d   = mem.cdata_rd;
         end
         S_RD2, S_RD3: begin
            state_d = (state_q == S_RD2) ? S_RD3 : S_WR;
            if (signed_gt(mem.cdata_rd, max_q)) max_d = mem.cdata_rd;
         end
         S_WR: begin
            ox_d    = ox_q + CW'(1);
            oy_d    = (ox_q == {CW{1'b1}}) ? oy_q + CW'(1) : oy_q;
            state_d = last_pixel ? S_FIN : S_RD0;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Port outputs are decoded from the next state so they appear registered in the state they belong to.
   always_comb begin
      row_odd    = (state_d == S_RD2) || (state_d == S_RD3);
      col_odd    = (state_d == S_RD1) || (state_d == S_RD3);
      busy_d     = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d     = (state_d == S_FIN);
      crd_d      = (state_d == S_RD0) || (state_d == S_RD1) ||
                   (state_d == S_RD2) || (state_d == S_RD3);
      cwr_d      = (state_d == S_WR);
      csel_d     = CSEL_IDLE;
      caddr_rd_d = '0;
      caddr_wr_d = '0;
      if (crd_d) begin
         csel_d     = CSEL_L0;
         caddr_rd_d = AW'({oy_d, row_odd, ox_d, col_odd});
      end
      if (cwr_d) begin
         csel_d     = CSEL_L1;
         caddr_wr_d = AW'({oy_d, ox_d});
      end
   end

   // The last pixel arrives during WR itself, so the final compare is combinational.
   always_comb begin
      mem.cdata_wr = '0;
      if (state_q == S_WR) begin
         mem.cdata_wr = signed_gt(mem.cdata_rd, max_q) ? mem.cdata_rd : max_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         crd_q      <= 1'b0;
         cwr_q      <= 1'b0;
         csel_q     <= CSEL_IDLE;
         caddr_rd_q <= '0;
         caddr_wr_q <= '0;
         oy_q       <= '0;
         ox_q       <= '0;
         max_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         crd_q      <= crd_d;
         cwr_q      <= cwr_d;
         csel_q     <= csel_d;
         caddr_rd_q <= caddr_rd_d;
         caddr_wr_q <= caddr_wr_d;
         oy_q       <= oy_d;
         ox_q       <= ox_d;
         max_q      <= max_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign mem.crd      = crd_q;
   assign mem.cwr      = cwr_q;
   assign mem.csel     = csel_q;
   assign mem.caddr_rd = caddr_rd_q;
   assign mem.caddr_wr = caddr_wr_q;

endmodule

// File: tb/tb_maxpool_engine.sv
// Bench for maxpool_engine: layer memories modelled as arrays, expected layer 1
// computed directly as the signed maximum of each 2x2 block.
module tb_maxpool_engine;

   localparam int IMG_W    = 64;
   localparam int DW       = 20;
   localparam int AW       = 12;
   localparam int OUT_W    = IMG_W / 2;
   localparam int NPIX     = IMG_W * IMG_W;
   localparam int NOUT     = OUT_W * OUT_W;
   localparam int PASS_CYC = 5121;
   localparam int LIMIT    = 6000;
   localparam logic [DW-1:0] SENT = 20'h5A5A5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   maxpool_engine_if #(.DW(DW), .AW(AW)) mem_if ();

   maxpool_engine #(.IMG_W(IMG_W), .DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .reset (rst_n),
      .start (start),
      .busy  (busy),
      .done  (done),
      .mem   (mem_if)
   );

   logic [DW-1:0] l0 [NPIX];
   logic [DW-1:0] l1 [NOUT];
   logic [DW-1:0] expv [NOUT];
   logic [DW-1:0] l1_first [NOUT];

   // Layer memory: registered read, write captured on the rising edge.
   always @(posedge clk) begin
      if (mem_if.crd) mem_if.cdata_rd <= l0[mem_if.caddr_rd];
      if (clr) begin
         for (int i = 0; i < NOUT; i++) l1[i] <= SENT;
      end else if (mem_if.cwr) begin
         l1[mem_if.caddr_wr[9:0]] <= mem_if.cdata_wr;
      end
   end

   int wr_cnt = 0, wr_base = 0, order_err = 0, done_cnt = 0, port_viol = 0;

   always @(negedge clk) begin
      port_viol <= port_viol + int'(mem_if.crd && mem_if.cwr)
                             + int'((mem_if.csel == 3'b011) != mem_if.cwr)
                             + int'((mem_if.csel == 3'b001) != mem_if.crd);
      if (mem_if.cwr) begin
         wr_cnt <= wr_cnt + 1;
         if (mem_if.caddr_wr != AW'(wr_cnt - wr_base)) order_err <= order_err + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void build_expected();
      logic signed [DW-1:0] m, v;
      for (int oy = 0; oy < OUT_W; oy++) begin
         for (int ox = 0; ox < OUT_W; ox++) begin
            m = l0[(2*oy)*IMG_W + 2*ox];
            for (int k = 1; k < 4; k++) begin
               v = l0[(2*oy + k/2)*IMG_W + 2*ox + k%2];
               if (v > m) m = v;
            end
            expv[oy*OUT_W + ox] = m;
         end
      end
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NPIX; i++) l0[i] = DW'($urandom);
   endtask

   task automatic clear_l1();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic compare_l1(input string tag);
      int errs = 0;
      for (int i = 0; i < NOUT; i++) if (l1[i] !== expv[i]) errs++;
      check(tag, errs, 0);
   endtask

   // Entered and left at a falling edge; returns in the idle cycle after done.
   task automatic run_pass(input string tag, input int repulse_at);
      int cycles, wr0, d0, oe0;
      wr0     = wr_cnt;
      wr_base = wr_cnt;
      d0      = done_cnt;
      oe0     = order_err;
      start   = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      check({tag, "_busy"}, busy, 1);
      while (!done && cycles < LIMIT) begin
         if (cycles == repulse_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cycles++;
      end
      check({tag, "_latency"}, cycles, PASS_CYC);
      @(negedge clk);
      check({tag, "_done_width"}, {busy, done}, 2'b00);
      check({tag, "_writes"}, wr_cnt - wr0, NOUT);
      check({tag, "_done_pulses"}, done_cnt - d0, 1);
      check({tag, "_order"}, order_err - oe0, 0);
   endtask

   initial begin
      int cycles, wr_snap, pv0;

      repeat (2) @(negedge clk);
      check("rst_busy_done", {busy, done}, 2'b00);
      check("rst_strobes", {mem_if.crd, mem_if.cwr, mem_if.csel}, 5'b0);
      check("rst_addr", {mem_if.caddr_rd, mem_if.caddr_wr}, 24'h0);
      check("rst_wdata", mem_if.cdata_wr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ramp image: each block max is its bottom-right pixel.
      for (int i = 0; i < NPIX; i++) l0[i] = DW'(i);
      build_expected();
      clear_l1();
      run_pass("ramp", -1);
      compare_l1("ramp_l1");
      check("ramp_l1_first", l1[0], 20'h00041);
      check("ramp_l1_last", l1[NOUT-1], 20'h00FFF);

      // A single maximum-positive pixel in each quadrant of block (5,7).
      for (int q = 0; q < 4; q++) begin
         for (int i = 0; i < NPIX; i++) l0[i] = '0;
         l0[(10 + q/2)*IMG_W + 14 + q%2] = 20'h7FFFF;
         build_expected();
         clear_l1();
         run_pass($sformatf("quad%0d", q), -1);
         compare_l1($sformatf("quad%0d_l1", q));
         check($sformatf("quad%0d_hit", q), l1[5*OUT_W + 7], 20'h7FFFF);
      end

      // Signed compare corner cases on top of random data.
      fill_random();
      l0[0]           = 20'h80000;
      l0[1]           = 20'hFFFFF;
      l0[IMG_W]       = 20'h00001;
      l0[IMG_W + 1]   = 20'hC0000;
      l0[6*IMG_W + 8] = 20'hFFFF0;
      l0[6*IMG_W + 9] = 20'hFFFFE;
      l0[7*IMG_W + 8] = 20'h80000;
      l0[7*IMG_W + 9] = 20'hFFFF8;
      build_expected();
      clear_l1();
      run_pass("signed", -1);
      compare_l1("signed_l1");
      check("signed_blk00", l1[0], 20'h00001);
      check("signed_allneg", l1[3*OUT_W + 4], 20'hFFFFE);

      // Start re-pulsed during RD0 of output 100 must be ignored.
      fill_random();
      build_expected();
      clear_l1();
      run_pass("repulse", 5*100 + 1);
      compare_l1("repulse_l1");

      // Reset during RD2 of output 200 (block oy=6, ox=8).
      fill_random();
      build_expected();
      clear_l1();
      wr_base = wr_cnt;
      wr_snap = wr_cnt;
      start   = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      while (cycles < 5*200 + 3) begin
         @(negedge clk);
         cycles++;
      end
      check("midrst_pre_addr", mem_if.caddr_rd, 13*IMG_W + 16);
      rst_n = 1'b0;
      #1;
      check("midrst_busy_done", {busy, done}, 2'b00);
      check("midrst_strobes", {mem_if.crd, mem_if.cwr, mem_if.csel}, 5'b0);
      check("midrst_addr", {mem_if.caddr_rd, mem_if.caddr_wr}, 24'h0);
      check("midrst_wdata", mem_if.cdata_wr, 0);
      repeat (5) @(negedge clk);
      check("midrst_partial_writes", wr_cnt - wr_snap, 200);
      check("midrst_last_written", l1[199], expv[199]);
      check("midrst_not_written", l1[200], SENT);
      rst_n = 1'b1;
      @(negedge clk);
      clear_l1();
      run_pass("postrst", -1);
      compare_l1("postrst_l1");

      // Back-to-back passes: second start in the idle cycle right after done.
      fill_random();
      build_expected();
      clear_l1();
      pv0 = port_viol;
      run_pass("b2b1", -1);
      compare_l1("b2b1_l1");
      for (int i = 0; i < NOUT; i++) l1_first[i] = l1[i];
      run_pass("b2b2", -1);
      begin
         int diffs = 0;
         for (int i = 0; i < NOUT; i++) if (l1[i] !== l1_first[i]) diffs++;
         check("b2b_identical", diffs, 0);
      end
      check("b2b_port_excl", port_viol - pv0, 0);
      check("port_excl_total", port_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/maxpool_engine.md
Name: maxpool_engine

Overview:
- Layer-1 stage of the CONV pipeline: reads the 64x64 layer-0 result (L0, csel=001), applies 2x2 stride-2 max-pooling and writes the 32x32 layer-1 result (L1, csel=011).
- Sits directly downstream of the convolution/ReLU stage. Shares the same cdata/caddr/csel memory port convention.
- Started by a one-cycle start pulse once layer 0 is complete.

Parameters:
- IMG_W, 64, input image width and height in pixels (power of two).
- DW, 20, pixel data width (signed 4.16 fixed point).
- AW, 12, memory address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a pooling pass; ignored while busy=1.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse in the cycle after the final L1 write.
- crd  output  1  read strobe to the layer memory.
- caddr_rd  output  AW  read address, row*IMG_W+col.
- cdata_rd  input  DW  read data, valid on the rising edge one cycle after crd/caddr_rd are presented.
- cwr  output  1  write strobe, captured by memory on the rising edge.
- caddr_wr  output  AW  write address, oy*(IMG_W/2)+ox, zero-extended.
- cdata_wr  output  DW  write data.
- csel  output  3  memory select: 001 during reads, 011 during the write cycle, 000 when idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr, oy, ox, running max all 0.
  - Effective immediately, including mid-pass. Partial L1 contents are left as written.
  - The next pass must start from output (0,0).
- States: IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> WR -> (RD0 | FIN) -> IDLE.
- IDLE:
  - outputs low.
  - start=1 -> RD0 next cycle, busy=1 from that cycle, oy=ox=0.
- Read addresses (crd=1, csel=001):
  - RD0 reads (2oy, 2ox).
  - RD1 reads (2oy, 2ox+1).
  - RD2 reads (2oy+1, 2ox).
  - RD3 reads (2oy+1, 2ox+1).
- Running max:
  - RD1 loads it with cdata_rd, which is pixel 0.
  - RD2 and RD3 replace it with cdata_rd if cdata_rd is greater (signed compare).
- WR:
  - crd=0, cwr=1, csel=011, caddr_wr=oy*32+ox.
  - cdata_wr = signed max(running max, cdata_rd), where cdata_rd is pixel 3.
  - cdata_wr may be combinational from cdata_rd but must be stable before the rising edge.
- Compare rules: full DW-bit two's-complement compare. Ties keep the earlier pixel (value is identical, so output is unaffected). No saturation or rounding; the output is an exact copy of one input.
- Counter advance in WR:
  - ox increments.
  - ox wraps 31->0 and oy increments.
  - After (oy,ox)=(31,31) the next state is FIN, otherwise RD0.
- FIN:
  - done=1 for exactly one cycle, busy=0 in the same cycle.
  - Return to IDLE.
- Throughput: 5 cycles per output pixel. One pass takes 5120 cycles from the first RD0 to the last WR, with done one cycle later.
- start:
  - While busy=1 or during FIN: ignored, with no effect on counters.
  - In IDLE the cycle after FIN: a start pulse begins a new pass normally.
- Memory port exclusivity: crd and cwr are never high in the same cycle. csel changes only on rising edges.
- Outputs are registered except cdata_wr (see WR) and are driven to 0 when inactive, never X.

Test Plan:
- L0[i]=i (0..4095), pulse start -> 1024 writes.
  - L1[oy*32+ox] = (2oy+1)*64+2ox+1, e.g. L1[0]=0x041 and L1[1023]=0xFFF.
  - done exactly 5121 cycles after the first RD0.
- L0 all 0x00000 except one 0x7FFFF at each of the 4 quadrant positions of block (5,7) in turn -> L1[5*32+7]=0x7FFFF, all other L1 entries 0.
- Signed check: block (0,0) = {0x80000, 0xFFFFF, 0x00001, 0xC0000} -> L1[0]=0x00001. Block with all four pixels negative {0xFFFF0, 0xFFFFE, 0x80000, 0xFFFF8} -> 0xFFFFE.
- start re-pulsed at output 100 mid-pass -> ignored: write sequence and addresses are unchanged, one done pulse at the end.
- reset=0 asserted during the RD2 cycle of output 200 -> all outputs 0 within the same cycle, no further writes. After release, start -> full correct pass from address 0.
- Back-to-back: start in the cycle after done -> second pass produces an identical L1. Throughout both passes, crd and cwr are never simultaneously high and csel is 011 only when cwr=1.
